ecg_rpeak_detector: RTL and testbench

- Downstream consumer of the 2-bit phase produced by `new_control`.
- Accepts streamed ECG samples only while the phase is ACQUIRE.
- Runs a two-tap derivative, threshold and refractory detector, and emits a one-cycle beat pulse.
- Reports the R-R interval in samples to the later HRV/output stage.

---
 rtl/ecg_pkg.sv | 21 ++
 rtl/ecg_deriv.sv | 53 +++++
 rtl/ecg_rpeak_detector.sv | 133 +++++++++++++
 tb/tb_ecg_rpeak_detector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared phase/state encodings and default constants for the R-peak detector
package ecg_pkg;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_THRESH  = 200;
    localparam int DEF_REFRACT = 50;
    localparam int DEF_RR_W    = 16;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_ACQ  = 2'b01;
    localparam logic [1:0] PH_PROC = 2'b10;
    localparam logic [1:0] PH_OUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRIME   = 2'b01,
        ST_SEARCH  = 2'b10,
        ST_REFRACT = 2'b11
    } state_t;

endpackage

// File: rtl/ecg_deriv.sv
// rtl/ecg_deriv.sv - two-sample delay line, signed two-tap derivative and saturating magnitude
module ecg_deriv
    import ecg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     accept,
    input  logic signed [DATA_W-1:0] sample,
    output logic        [DATA_W:0]   mag,
    output logic                     primed
);

    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic        [1:0]        hist_cnt;
    logic signed [DATA_W:0]   d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1       <= '0;
            x2       <= '0;
            hist_cnt <= '0;
        end else if (clr) begin
            x1       <= '0;
            x2       <= '0;
            hist_cnt <= '0;
        end else if (accept) begin
            x2 <= x1;
            x1 <= sample;
            if (hist_cnt != 2'd2)
                hist_cnt <= hist_cnt + 2'd1;
        end
    end

    // One extra bit of headroom makes the subtract exact for any pair of samples.
    assign d = {sample[DATA_W-1], sample} - {x2[DATA_W-1], x2};

    always_comb begin
        mag = $unsigned(d);
        if (d[DATA_W]) begin
            if (d == {1'b1, {DATA_W{1'b0}}})
                mag = '1;
            else
                mag = $unsigned(-d);
        end
    end

    assign primed = (hist_cnt == 2'd2);

endmodule

// File: rtl/ecg_rpeak_detector.sv
// rtl/ecg_rpeak_detector.sv - threshold/refractory R-peak detector with R-R interval; ECG_ADAPT_THRESH_EN enables adaptive threshold
module ecg_rpeak_detector
    import ecg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int THRESH  = DEF_THRESH,
    parameter int REFRACT = DEF_REFRACT,
    parameter int RR_W    = DEF_RR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               phase,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample,
    output logic                     beat,
    output logic                     rr_valid,
    output logic [RR_W-1:0]          rr_interval,
    output logic                     busy
);

    localparam int              REF_W    = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
    localparam logic [REF_W-1:0] REF_INIT = REF_W'(REFRACT);
    localparam logic [DATA_W:0]  THR_INIT = (DATA_W+1)'(THRESH);

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              clr;
    logic              detect;
    logic [DATA_W:0]   mag;
    logic              primed;
    logic [DATA_W:0]   thr;
    logic [RR_W-1:0]   samp_cnt;
    logic [RR_W-1:0]   rr_next;
    logic [REF_W-1:0]  ref_cnt;
    logic              have_prev;

    assign accept = sample_valid && (phase == PH_ACQ);
    assign clr    = (phase == PH_IDLE) && (state != ST_IDLE);
    assign busy   = (state != ST_IDLE);

    // PRIME may detect as soon as two history samples exist, so no sample is lost while leaving PRIME.
    assign detect = accept && (mag > thr) &&
                    ((state == ST_SEARCH) || ((state == ST_PRIME) && primed));

    ecg_deriv #(
        .DATA_W (DATA_W)
    ) u_deriv (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .accept (accept),
        .sample (sample),
        .mag    (mag),
        .primed (primed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (phase == PH_ACQ) state_nx = ST_PRIME;
                ST_PRIME:   if (detect) state_nx = ST_REFRACT;
                            else if (primed && (phase == PH_ACQ)) state_nx = ST_SEARCH;
                ST_SEARCH:  if (detect) state_nx = ST_REFRACT;
                ST_REFRACT: if (accept && (ref_cnt <= REF_W'(1))) state_nx = ST_SEARCH;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    assign rr_next = (samp_cnt == '1) ? '1 : samp_cnt + RR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat        <= 1'b0;
            rr_valid    <= 1'b0;
            rr_interval <= '0;
            samp_cnt    <= '0;
            ref_cnt     <= '0;
            have_prev   <= 1'b0;
        end else begin
            beat     <= detect;
            rr_valid <= detect && have_prev;
            if (clr) begin
                ref_cnt   <= '0;
                have_prev <= 1'b0;
            end else if (detect) begin
                samp_cnt  <= '0;
                have_prev <= 1'b1;
                ref_cnt   <= REF_INIT;
                if (have_prev)
                    rr_interval <= rr_next;
            end else if (accept) begin
                if (samp_cnt != '1)
                    samp_cnt <= samp_cnt + RR_W'(1);
                if ((state == ST_REFRACT) && (ref_cnt != '0))
                    ref_cnt <= ref_cnt - REF_W'(1);
            end
        end
    end

`ifdef ECG_ADAPT_THRESH_EN
    localparam logic [DATA_W:0] THR_FLOOR = (DATA_W+1)'(THRESH >> 2);

    logic [DATA_W+1:0] thr_sum;
    logic [DATA_W:0]   thr_avg;

    assign thr_sum = {1'b0, thr} + {2'b00, mag[DATA_W:1]};
    assign thr_avg = thr_sum[DATA_W+1:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            thr <= THR_INIT;
        else if (clr)
            thr <= THR_INIT;
        else if (detect)
            thr <= (thr_avg < THR_FLOOR) ? THR_FLOOR : thr_avg;
    end
`else
    assign thr = THR_INIT;
`endif

endmodule

// File: tb/tb_ecg_rpeak_detector.sv
// tb/tb_ecg_rpeak_detector.sv - self-checking bench for ecg_rpeak_detector against a sample-level model
module tb_ecg_rpeak_detector;

    localparam int THRESH  = 200;
    localparam int REFRACT = 50;
    localparam int RR_MAX  = 65535;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         phase = 2'b00;
    logic               sample_valid = 1'b0;
    logic signed [11:0] sample = '0;
    logic               beat;
    logic               rr_valid;
    logic [15:0]        rr_interval;
    logic               busy;

    int tests = 0;
    int fails = 0;

    int m_x1, m_x2, m_hist, m_blind, m_samp, m_have_prev, m_thr, m_rr, m_busy;
    int exp_beat, exp_rrv;

    ecg_rpeak_detector dut (
        .clk          (clk),
        .rst          (rst),
        .phase        (phase),
        .sample_valid (sample_valid),
        .sample       (sample),
        .beat         (beat),
        .rr_valid     (rr_valid),
        .rr_interval  (rr_interval),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_x1 = 0; m_x2 = 0; m_hist = 0; m_blind = 0; m_samp = 0;
        m_have_prev = 0; m_thr = THRESH; m_rr = 0; m_busy = 0;
        exp_beat = 0; exp_rrv = 0;
    endtask

    // Sample-level reference: beat when two prior samples exist, outside the blind window, and |s - x2| > thr.
    task automatic model(input logic [1:0] ph, input logic v, input int s);
        int a;
        exp_beat = 0;
        exp_rrv  = 0;
        if (ph == 2'b00) begin
            m_x1 = 0; m_x2 = 0; m_hist = 0; m_blind = 0; m_have_prev = 0;
            m_thr = THRESH; m_busy = 0;
        end else if (ph == 2'b01) begin
            m_busy = 1;
            if (v) begin
                a = s - m_x2;
                if (a < 0) a = -a;
                if (m_hist >= 2 && m_blind == 0 && a > m_thr) begin
                    exp_beat = 1;
                    if (m_have_prev != 0) begin
                        exp_rrv = 1;
                        m_rr = (m_samp + 1 > RR_MAX) ? RR_MAX : m_samp + 1;
                    end
                    m_samp = 0;
                    m_have_prev = 1;
                    m_blind = REFRACT;
`ifdef ECG_ADAPT_THRESH_EN
                    m_thr = (m_thr + a / 2) / 2;
                    if (m_thr < THRESH / 4) m_thr = THRESH / 4;
`endif
                end else begin
                    if (m_blind > 0) m_blind--;
                    if (m_samp < RR_MAX) m_samp++;
                end
                m_x2 = m_x1;
                m_x1 = s;
                if (m_hist < 2) m_hist++;
            end
        end
    endtask

    task automatic step(input logic [1:0] ph, input logic v, input int s);
        phase        = ph;
        sample_valid = v;
        sample       = 12'(s);
        @(posedge clk);
        #1;
        model(ph, v, s);
        check("beat", int'(beat), exp_beat);
        check("rr_valid", int'(rr_valid), exp_rrv);
        check("rr_interval", int'(rr_interval), m_rr);
        check("busy", int'(busy), m_busy);
    endtask

    task automatic feed(input int n, input int val);
        for (int i = 0; i < n; i++) step(2'b01, 1'b1, val);
    endtask

    initial begin
        int r, ph_r, s_r;
        logic [1:0] ph;

        model_reset();
        #1;
        check("rst_beat", int'(beat), 0);
        check("rst_rr_valid", int'(rr_valid), 0);
        check("rst_rr_interval", int'(rr_interval), 0);
        check("rst_busy", int'(busy), 0);
        phase = 2'b01; sample_valid = 1'b1; sample = 12'sd500;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_beat", int'(beat), 0);
        check("rst_hold_busy", int'(busy), 0);
        rst = 1'b0;

        // Flat input: derivative stays below threshold.
        feed(100, 100);
        check("flat_busy", int'(busy), 1);

        // First spike: beat one cycle after accept, no interval yet.
        feed(10, 0);
        feed(1, 300);
        check("first_beat", int'(beat), 1);
        check("first_no_rr", int'(rr_valid), 0);

        // Second spike 120 samples later reports the interval.
        feed(119, 0);
        feed(1, 300);
        check("second_beat", int'(beat), 1);
        check("second_rr_valid", int'(rr_valid), 1);
        check("second_rr", int'(rr_interval), 120);

        // Spike inside the refractory window is ignored.
        feed(29, 0);
        feed(1, 300);
        check("refract_no_beat", int'(beat), 0);
        feed(5, 0);

        // PROCESS/OUTPUT freeze everything even with valid samples.
        for (int i = 0; i < 20; i++) step((i < 10) ? 2'b10 : 2'b11, 1'b1, (i % 2) ? 1500 : -1500);
        check("freeze_no_beat", int'(beat), 0);
        feed(60, 0);

        // A would-be detection presented with phase IDLE clears instead.
        step(2'b00, 1'b1, 300);
        check("clr_no_beat", int'(beat), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_rr_hold", int'(rr_interval), 120);

        // Randomized phases, qualifiers, noise and spikes.
        for (int i = 0; i < 2000; i++) begin
            ph_r = int'($urandom_range(0, 99));
            ph = (ph_r < 85) ? 2'b01 : (ph_r < 93) ? 2'b10 : (ph_r < 97) ? 2'b11 : 2'b00;
            r = int'($urandom_range(0, 99));
            if (r < 6)
                s_r = int'($urandom_range(0, 4000)) - 2000;
            else
                s_r = int'($urandom_range(0, 40)) - 20;
            step(ph, ($urandom_range(0, 3) != 0), s_r);
        end

        // R-R counter saturation.
        feed(60, 0);
        feed(1, 300);
        check("sat_first_beat", int'(beat), 1);
        feed(70000, 0);
        feed(1, 300);
        check("sat_beat", int'(beat), 1);
        check("sat_rr_valid", int'(rr_valid), 1);
        check("sat_rr", int'(rr_interval), 65535);

        // Asynchronous reset while a beat pulse is in flight.
        feed(60, 0);
        feed(1, 300);
        check("pre_rst_beat", int'(beat), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_beat", int'(beat), 0);
        check("arst_rr_valid", int'(rr_valid), 0);
        check("arst_rr_interval", int'(rr_interval), 0);
        check("arst_busy", int'(busy), 0);
        rst = 1'b0;
        model_reset();
        feed(10, 0);
        feed(1, 300);
        check("post_rst_beat", int'(beat), 1);
        check("post_rst_no_rr", int'(rr_valid), 0);
        feed(5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
